eprisc_bus_arbiter: RTL and testbench

- Two-requester round-robin arbiter and sequencer for the I/O controller's internal peripheral bus (15-bit address, 16-bit write data, 32-bit read data).
- Requester A is the host SPI byte pipeline; requester B is an on-chip agent (e.g. a DMA or refresh engine).
- Grants one requester per transaction, decodes the address into peripheral enables, and sequences setup, write strobe and ready wait.
- Returns read data with an ack/error pulse; a timeout recovers from a peripheral that never signals ready.

---
 rtl/eprisc_bus_arbiter.sv | 127 ++++++++++++
 tb/tb_eprisc_bus_arbiter.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/eprisc_bus_arbiter.sv
// Two-requester round-robin arbiter and sequencer for the I/O controller's peripheral bus.
// One transaction at a time: IDLE -> SETUP -> ACCESS (wait ready / timeout) -> DONE.
module eprisc_bus_arbiter #(
  parameter int ADDR_W  = 15,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 16
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic              iReqA,
  input  logic              iWriteA,
  input  logic [ADDR_W-1:0] iAddrA,
  input  logic [DATA_W-1:0] iDataA,
  output logic              oAckA,
  output logic              oErrA,
  output logic [31:0]       oDataA,
  input  logic              iReqB,
  input  logic              iWriteB,
  input  logic [ADDR_W-1:0] iAddrB,
  input  logic [DATA_W-1:0] iDataB,
  output logic              oAckB,
  output logic              oErrB,
  output logic [31:0]       oDataB,
  output logic [ADDR_W-1:0] oBusAddress,
  output logic [DATA_W-1:0] oBusData,
  output logic              oBusWrite,
  output logic              oEnableGPIO,
  output logic              oEnableRAM,
  input  logic [31:0]       iBusMISO,
  input  logic              iBusReady
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

  localparam int CW = ($clog2(TIMEOUT) < 5) ? 5 : $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic              gnt_q;   // 1 = B owns the current transaction
  logic              last_q;  // 1 = B was granted most recently
  logic              wr_q, err_q;
  logic [CW-1:0]     cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [31:0]       rdata_a_q, rdata_b_q;

  logic any_req, pick_b, mapped, timeout, in_window;

  assign any_req = iReqA | iReqB;
  // Under contention the requester that was not granted last wins.
  assign pick_b  = iReqB & (~iReqA | ~last_q);
  assign mapped  = (addr_q >> 9) == '0;
  assign timeout = cnt_q == CNT_LAST;

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (any_req) state_d = SETUP;
      SETUP:   state_d = mapped ? ACCESS : DONE;
      ACCESS:  if (iBusReady || timeout) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      gnt_q     <= 1'b0;
      last_q    <= 1'b1;
      wr_q      <= 1'b0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_a_q <= '0;
      rdata_b_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: if (any_req) begin
          gnt_q   <= pick_b;
          last_q  <= pick_b;
          wr_q    <= pick_b ? iWriteB : iWriteA;
          addr_q  <= pick_b ? iAddrB  : iAddrA;
          wdata_q <= pick_b ? iDataB  : iDataA;
          cnt_q   <= '0;
        end
        SETUP: begin
          cnt_q <= '0;
          if (!mapped) err_q <= 1'b1;
        end
        ACCESS: begin
          cnt_q <= cnt_q + 1'b1;
          // Ready in the timeout cycle still completes cleanly.
          if (iBusReady) begin
            if (!wr_q && !gnt_q) rdata_a_q <= iBusMISO;
            if (!wr_q &&  gnt_q) rdata_b_q <= iBusMISO;
          end else if (timeout) begin
            err_q <= 1'b1;
            if (!wr_q && !gnt_q) rdata_a_q <= '1;
            if (!wr_q &&  gnt_q) rdata_b_q <= '1;
          end
        end
        default: err_q <= 1'b0;
      endcase
    end
  end

  always_comb begin
    in_window   = (state_q == SETUP) || (state_q == ACCESS);
    oEnableGPIO = in_window & mapped & ~addr_q[8];
    oEnableRAM  = in_window & mapped &  addr_q[8];
    oBusWrite   = (state_q == ACCESS) & wr_q & (cnt_q == '0);
    oAckA       = (state_q == DONE) & ~gnt_q;
    oAckB       = (state_q == DONE) &  gnt_q;
    oErrA       = oAckA & err_q;
    oErrB       = oAckB & err_q;
    oBusAddress = addr_q;
    oBusData    = wdata_q;
    oDataA      = rdata_a_q;
    oDataB      = rdata_b_q;
  end

endmodule

// File: tb/tb_eprisc_bus_arbiter.sv
// Directed bench for eprisc_bus_arbiter: read/write, alternation, timeout, unmapped, mid-flight reset.
module tb_eprisc_bus_arbiter;
  logic        iClk = 1'b0, iRst = 1'b0;
  logic        iReqA = 0, iWriteA = 0, iReqB = 0, iWriteB = 0;
  logic [14:0] iAddrA = '0, iAddrB = '0;
  logic [15:0] iDataA = '0, iDataB = '0;
  logic        oAckA, oErrA, oAckB, oErrB, oBusWrite, oEnableGPIO, oEnableRAM;
  logic [31:0] oDataA, oDataB, iBusMISO = '0;
  logic [14:0] oBusAddress;
  logic [15:0] oBusData;
  logic        iBusReady = 1'b0;
  int          n_chk = 0, n_fail = 0;

  eprisc_bus_arbiter #(.ADDR_W(15), .DATA_W(16), .TIMEOUT(16)) dut (
    .iClk(iClk), .iRst(iRst),
    .iReqA(iReqA), .iWriteA(iWriteA), .iAddrA(iAddrA), .iDataA(iDataA),
    .oAckA(oAckA), .oErrA(oErrA), .oDataA(oDataA),
    .iReqB(iReqB), .iWriteB(iWriteB), .iAddrB(iAddrB), .iDataB(iDataB),
    .oAckB(oAckB), .oErrB(oErrB), .oDataB(oDataB),
    .oBusAddress(oBusAddress), .oBusData(oBusData), .oBusWrite(oBusWrite),
    .oEnableGPIO(oEnableGPIO), .oEnableRAM(oEnableRAM),
    .iBusMISO(iBusMISO), .iBusReady(iBusReady)
  );

  always #5 iClk = ~iClk;

  task automatic tick;
    @(posedge iClk); #1;
  endtask

  function automatic logic [31:0] all_out();
    return {oAckA, oErrA, oAckB, oErrB, oBusWrite, oEnableGPIO, oEnableRAM} |
           oDataA | oDataB | 32'(oBusAddress) | 32'(oBusData);
  endfunction

  task automatic test_reset;
    iRst = 1'b1; tick; tick;
    n_chk++; if (all_out() !== 32'h0) begin n_fail++; $display("FAIL reset_outputs got %h exp 0", all_out()); end
    iRst = 1'b0; tick;
    n_chk++; if (all_out() !== 32'h0) begin n_fail++; $display("FAIL idle_outputs got %h exp 0", all_out()); end
  endtask

  task automatic test_read_a;
    int wr = 0;
    iReqA = 1; iWriteA = 0; iAddrA = 15'h034; iBusReady = 1; iBusMISO = 32'hDEADBEEF;
    for (int c = 1; c <= 3; c++) begin
      tick;
      wr += int'(oBusWrite);
      if (c < 3) begin
        n_chk++; if (oEnableGPIO !== 1'b1 || oEnableRAM !== 1'b0 || oAckA !== 1'b0) begin
          n_fail++; $display("FAIL read_en c%0d gpio=%b ram=%b ack=%b exp 1/0/0", c, oEnableGPIO, oEnableRAM, oAckA); end
      end
    end
    n_chk++; if (oAckA !== 1'b1 || oErrA !== 1'b0 || oEnableGPIO !== 1'b0) begin
      n_fail++; $display("FAIL read_ack ack=%b err=%b gpio=%b exp 1/0/0", oAckA, oErrA, oEnableGPIO); end
    n_chk++; if (oDataA !== 32'hDEADBEEF) begin n_fail++; $display("FAIL read_data got %h exp deadbeef", oDataA); end
    iReqA = 0; tick;
    n_chk++; if (oAckA !== 1'b0 || wr !== 0) begin n_fail++; $display("FAIL read_post ack=%b writes=%0d exp 0/0", oAckA, wr); end
  endtask

  task automatic test_write_a;
    int wr = 0;
    iReqA = 1; iWriteA = 1; iAddrA = 15'h134; iDataA = 16'h1234; iBusReady = 1; iBusMISO = 32'hCAFEF00D;
    for (int c = 1; c <= 4; c++) begin
      tick;
      wr += int'(oBusWrite);
      if (c == 1) begin
        n_chk++; if (oEnableRAM !== 1'b1 || oEnableGPIO !== 1'b0 || oBusAddress !== 15'h134 || oBusData !== 16'h1234) begin
          n_fail++; $display("FAIL write_setup ram=%b gpio=%b addr=%h data=%h exp 1/0/134/1234", oEnableRAM, oEnableGPIO, oBusAddress, oBusData); end
      end
      if (c == 3) begin
        n_chk++; if (oAckA !== 1'b1 || oErrA !== 1'b0 || oDataA !== 32'hDEADBEEF) begin
          n_fail++; $display("FAIL write_ack ack=%b err=%b data=%h exp 1/0/deadbeef", oAckA, oErrA, oDataA); end
        iReqA = 0; iWriteA = 0;
      end
    end
    n_chk++; if (wr !== 1) begin n_fail++; $display("FAIL write_strobe got %0d cycles exp 1", wr); end
  endtask

  task automatic test_alternate;
    int nack = 0, order[4];
    logic pa = 0, pb = 0;
    iRst = 1; tick; iRst = 0;
    iReqA = 1; iAddrA = 15'h010; iReqB = 1; iAddrB = 15'h110; iBusReady = 1; iBusMISO = 32'h11112222;
    for (int t = 0; t < 30 && nack < 4; t++) begin
      tick;
      n_chk++; if ((oAckA && oAckB) || (oAckA && pa) || (oAckB && pb)) begin
        n_fail++; $display("FAIL alt_ack_shape t%0d ackA=%b ackB=%b", t, oAckA, oAckB); end
      if (oAckA) order[nack++] = 0;
      else if (oAckB) order[nack++] = 1;
      pa = oAckA; pb = oAckB;
    end
    iReqA = 0; iReqB = 0;
    n_chk++; if (nack !== 4) begin n_fail++; $display("FAIL alt_count got %0d exp 4", nack); end
    else begin
      n_chk++; if (order[0] !== 0 || order[1] !== 1 || order[2] !== 0 || order[3] !== 1) begin
        n_fail++; $display("FAIL alt_order got %0d%0d%0d%0d exp 0101", order[0], order[1], order[2], order[3]); end
    end
    tick;
  endtask

  task automatic test_timeout_b;
    int n = 0, en = 0;
    iReqB = 1; iWriteB = 0; iAddrB = 15'h050; iBusReady = 0;
    while (!oAckB && n < 40) begin tick; n++; en += int'(oEnableGPIO); end
    n_chk++; if (n !== 18 || en !== 17) begin n_fail++; $display("FAIL to_latency got %0d/%0d exp 18/17", n, en); end
    n_chk++; if (oErrB !== 1'b1 || oDataB !== 32'hFFFFFFFF) begin
      n_fail++; $display("FAIL to_err err=%b data=%h exp 1/ffffffff", oErrB, oDataB); end
    iReqB = 0; tick;
    iReqB = 1;
    for (int c = 1; c <= 17; c++) tick;
    n_chk++; if (oAckB !== 1'b0) begin n_fail++; $display("FAIL to_early_ack got %b exp 0", oAckB); end
    iBusReady = 1; iBusMISO = 32'h0BADF00D;
    tick;
    iBusReady = 0;
    n_chk++; if (oAckB !== 1'b1 || oErrB !== 1'b0 || oDataB !== 32'h0BADF00D) begin
      n_fail++; $display("FAIL to_ready_wins ack=%b err=%b data=%h exp 1/0/0badf00d", oAckB, oErrB, oDataB); end
    iReqB = 0; tick;
  endtask

  task automatic test_unmapped_a;
    iReqA = 1; iWriteA = 0; iAddrA = 15'h300; iBusReady = 1;
    tick;
    n_chk++; if (oEnableGPIO !== 1'b0 || oEnableRAM !== 1'b0 || oAckA !== 1'b0) begin
      n_fail++; $display("FAIL unmap_setup gpio=%b ram=%b ack=%b exp 0/0/0", oEnableGPIO, oEnableRAM, oAckA); end
    tick;
    n_chk++; if (oAckA !== 1'b1 || oErrA !== 1'b1 || oEnableGPIO !== 1'b0 || oEnableRAM !== 1'b0) begin
      n_fail++; $display("FAIL unmap_ack ack=%b err=%b exp 1/1", oAckA, oErrA); end
    iReqA = 0; tick;
  endtask

  task automatic test_reset_mid;
    iReqA = 1; iWriteA = 1; iAddrA = 15'h120; iDataA = 16'hABCD; iBusReady = 0;
    tick; tick;
    n_chk++; if (oBusWrite !== 1'b1 || oEnableRAM !== 1'b1) begin
      n_fail++; $display("FAIL rst_access wr=%b ram=%b exp 1/1", oBusWrite, oEnableRAM); end
    iRst = 1; #1;
    n_chk++; if (all_out() !== 32'h0) begin n_fail++; $display("FAIL rst_async got %h exp 0", all_out()); end
    tick;
    n_chk++; if (oAckA !== 1'b0 || all_out() !== 32'h0) begin n_fail++; $display("FAIL rst_no_ack got %h exp 0", all_out()); end
    iRst = 0; iReqB = 1; iWriteB = 0; iAddrB = 15'h010; iBusReady = 1;
    tick;
    n_chk++; if (oBusAddress !== 15'h120 || oEnableRAM !== 1'b1) begin
      n_fail++; $display("FAIL rst_first_grant addr=%h ram=%b exp 120/1", oBusAddress, oEnableRAM); end
    tick; tick;
    n_chk++; if (oAckA !== 1'b1 || oAckB !== 1'b0) begin n_fail++; $display("FAIL rst_a_ack ackA=%b ackB=%b exp 1/0", oAckA, oAckB); end
    iReqA = 0; iWriteA = 0;
    tick; tick; tick; tick;
    n_chk++; if (oAckB !== 1'b1) begin n_fail++; $display("FAIL rst_b_ack got %b exp 1", oAckB); end
    iReqB = 0; tick;
  endtask

  initial begin
    test_reset;
    test_read_a;
    test_write_a;
    test_alternate;
    test_timeout_b;
    test_unmapped_a;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
